// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: opcode/funct constants, the hazard
// controller state encoding and a decode helper.
package dlx_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_MULT = 6'h01;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h12;

  typedef enum logic [1:0] {RUN, MULT, FLUSH} hz_state_t;

  // Opcodes that read Rt as a source (R-type, BEQ compare, SW store data).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_R) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_loaduse.sv
// hazard_loaduse_detect: combinational load-use compare between the load in
// EX (ID/EX) and the instruction in ID (IF/ID).
//   ifid_opcode/ifid_rs/ifid_rt : instruction in ID
//   idex_memread/idex_rt        : load in EX and its destination
//   stall_req                   : one-cycle stall request
// Register 0 never stalls.
module hazard_loaduse_detect
  import dlx_pkg::*;
(
  input  logic [5:0] ifid_opcode,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  output logic       stall_req
);

  assign stall_req = idex_memread && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) ||
                      (reads_rt(ifid_opcode) && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage DLX pipeline.
//   Inputs : clk, rst (sync, active-high), ID/EX and IF/ID fields, and the
//            branch/jump/JR redirect requests from ID.
//   Outputs: PC / IF/ID / ID/EX enables, bubble and flush controls, and the
//            multiplier start/busy handshake.
// Optional macro HAZARD_PERF_EN adds saturating stall_cycles and
// flush_events counters.
// Outputs are combinational from state and inputs; rst forces reset values.
module pipeline_hazard_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned MULT_LAT  = 4,
  parameter int unsigned FLUSH_LEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  IFID_Opcode,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic [5:0]  IDEX_Opcode,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic        branchCheck,
  input  logic        JumpCheck,
  input  logic        JRCheck,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        CtrlBubble,
  output logic        EXMEMBubble,
  output logic        IFflush,
  output logic        IDflush,
  output logic        mult_start,
  output logic        mult_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  localparam logic [3:0] MULT_CNT  = 4'(MULT_LAT - 1);
  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_LEN - 1);

  hz_state_t  state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       mult_seen, mult_seen_n;
  logic       lu_stall;
  logic       redirect;
  logic       redirect_acc;

  assign redirect = branchCheck | JumpCheck | JRCheck;

  hazard_loaduse_detect u_loaduse (
    .ifid_opcode  (IFID_Opcode),
    .ifid_rs      (IFID_Rs),
    .ifid_rt      (IFID_Rt),
    .idex_memread (IDEX_MemRead),
    .idex_rt      (IDEX_Rt),
    .stall_req    (lu_stall)
  );

  always_comb begin
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    CtrlBubble   = 1'b0;
    EXMEMBubble  = 1'b0;
    IFflush      = 1'b0;
    IDflush      = 1'b0;
    mult_start   = 1'b0;
    mult_busy    = 1'b0;
    redirect_acc = 1'b0;
    state_n      = state;
    cnt_n        = cnt;
    if (!rst) begin
      case (state)
        RUN: begin
          if ((IDEX_Opcode == OP_MULT) && !mult_seen) begin
            mult_start  = 1'b1;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
            cnt_n       = MULT_CNT;
            state_n     = MULT;
          end else if (redirect) begin
            IFflush      = 1'b1;
            IDflush      = 1'b1;
            redirect_acc = 1'b1;
            if (FLUSH_LEN > 1) begin
              cnt_n   = FLUSH_CNT;
              state_n = FLUSH;
            end
          end else if (lu_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            CtrlBubble = 1'b1;
          end
        end
        MULT: begin
          // cnt==0 is the release cycle: result goes to EX/MEM, pipe moves.
          if (cnt == 4'd0) begin
            state_n = RUN;
          end else begin
            mult_busy   = 1'b1;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
            cnt_n       = cnt - 4'd1;
          end
        end
        FLUSH: begin
          IFflush = 1'b1;
          if (redirect) begin
            redirect_acc = 1'b1;
            cnt_n        = FLUSH_CNT;
          end else if (cnt <= 4'd1) begin
            // This cycle's decrement reaches zero, so the window ends here.
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  // mult_seen marks an ID/EX occupant whose Mult must not be (re)started:
  // set on reset so an abandoned Mult is not re-pulsed, cleared as soon as
  // ID/EX loads a new instruction.
  assign mult_seen_n = IDEXWrite ? 1'b0 : mult_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      mult_seen <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mult_seen <= mult_seen_n;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!PCWrite && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_acc && (flush_events != '1))
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule
